// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Brief    : Shared constants and types for the cnn pixel pipeline and its
//            output-side consumers (score vector layout, reducer states).
// Revision : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  // Class scores produced per output pixel and the width of each score
  localparam int CNN_CHANNELS_OUT = 5;
  localparam int CNN_SCORE_W      = 16;

  // One signed class score and the packed per-pixel score vector
  typedef logic signed [CNN_SCORE_W-1:0] score_t;
  typedef score_t [CNN_CHANNELS_OUT-1:0] score_vec_t;

  // Frame reducer phases: summing pixels, searching the winner, holding result
  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    ARGMAX = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/score_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : score_accumulator
// Brief    : Single-channel signed running sum with add-enable and
//            synchronous clear. Clear has priority over add.
// Revision : 1.0 - initial release
// ============================================================================
module score_accumulator #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 28
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    add_en,
  input  logic signed [IN_W-1:0]  din,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_din_ext;

  // Two's-complement sign extension of the incoming score
  assign w_din_ext = {{(ACC_W-IN_W){din[IN_W-1]}}, din};

  // Running sum: clear at end of argmax, otherwise add each accepted score
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (add_en) begin
      r_acc <= r_acc + w_din_ext;
    end
  end

  assign acc = r_acc;

endmodule : score_accumulator
`default_nettype wire

// File: rtl/cnn_score_reducer.sv
`default_nettype none
// ============================================================================
// Module   : cnn_score_reducer
// Brief    : Sums per-class scores over an output frame, then runs a
//            sequential argmax and offers the winning class on a
//            valid/ready handshake. Pixels arriving while busy are dropped
//            and flagged on a sticky overrun bit.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_score_reducer
  import cnn_pkg::*;
#(
  parameter int CHANNELS_OUT = CNN_CHANNELS_OUT,
  parameter int SCORE_W      = CNN_SCORE_W,
  parameter int OUT_PIXELS   = 2048,
  localparam int ACC_W       = SCORE_W + $clog2(OUT_PIXELS) + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clk_en,
  input  logic [SCORE_W*CHANNELS_OUT-1:0]   in_data,
  input  logic                              in_valid,
  output logic [$clog2(CHANNELS_OUT)-1:0]   class_id,
  output logic [ACC_W-1:0]                  class_score,
  output logic                              result_valid,
  input  logic                              result_ready,
  output logic                              overrun
);

  localparam int ID_W  = $clog2(CHANNELS_OUT);
  // The index walks one step past the last channel to publish the result
  localparam int IDX_W = $clog2(CHANNELS_OUT + 1);
  localparam int CNT_W = (OUT_PIXELS > 1) ? $clog2(OUT_PIXELS) : 1;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [CNT_W-1:0]         r_pix_cnt;
  logic [IDX_W-1:0]         r_idx;
  logic [ID_W-1:0]          r_best_idx;
  logic signed [ACC_W-1:0]  r_best;
  logic [ID_W-1:0]          r_class_id;
  logic signed [ACC_W-1:0]  r_class_score;
  logic                     r_result_valid;
  logic                     r_overrun;

  logic signed [ACC_W-1:0]  w_acc [CHANNELS_OUT];
  logic signed [ACC_W-1:0]  w_cand;
  logic                     w_acc_add;
  logic                     w_acc_clr;
  logic                     w_pix_last;
  logic                     w_publish;
  logic                     w_take;

  // One accumulator per class, all fed from their slice of the score vector
  for (genvar c = 0; c < CHANNELS_OUT; c++) begin : g_acc
    score_accumulator #(
      .IN_W  (SCORE_W),
      .ACC_W (ACC_W)
    ) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (w_acc_clr),
      .add_en (w_acc_add),
      .din    (in_data[SCORE_W*c +: SCORE_W]),
      .acc    (w_acc[c])
    );
  end

  assign w_pix_last = (r_pix_cnt == CNT_W'(OUT_PIXELS - 1));
  assign w_publish  = (r_idx == IDX_W'(CHANNELS_OUT));

  // Select the accumulator under inspection; zero once past the last channel
  always_comb begin
    w_cand = '0;
    for (int c = 0; c < CHANNELS_OUT; c++) begin
      if (r_idx == IDX_W'(c)) begin
        w_cand = w_acc[c];
      end
    end
  end

  // First channel always seeds the search; later ones must be strictly larger
  assign w_take = (r_idx == '0) || (w_cand > r_best);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else if (clk_en) begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and accumulator controls
  always_comb begin
    w_state_next = r_state;
    w_acc_add    = 1'b0;
    w_acc_clr    = 1'b0;
    if (clk_en) begin
      case (r_state)
        ACCUM: begin
          if (in_valid) begin
            w_acc_add = 1'b1;
            if (w_pix_last) begin
              w_state_next = ARGMAX;
            end
          end
        end
        ARGMAX: begin
          if (w_publish) begin
            w_acc_clr    = 1'b1;
            w_state_next = DONE;
          end
        end
        DONE: begin
          if (result_ready) begin
            w_state_next = ACCUM;
          end
        end
        default: w_state_next = ACCUM;
      endcase
    end
  end

  // Pixel counting, argmax walk, result publication and overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt      <= '0;
      r_idx          <= '0;
      r_best_idx     <= '0;
      r_best         <= '0;
      r_class_id     <= '0;
      r_class_score  <= '0;
      r_result_valid <= 1'b0;
      r_overrun      <= 1'b0;
    end else if (clk_en) begin
      if (in_valid && (r_state != ACCUM)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ACCUM: begin
          if (in_valid) begin
            r_pix_cnt <= w_pix_last ? '0 : r_pix_cnt + 1'b1;
          end
        end
        ARGMAX: begin
          if (w_publish) begin
            r_class_id     <= r_best_idx;
            r_class_score  <= r_best;
            r_result_valid <= 1'b1;
            r_idx          <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
            if (w_take) begin
              r_best     <= w_cand;
              r_best_idx <= ID_W'(r_idx);
            end
          end
        end
        DONE: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign class_id     = r_class_id;
  assign class_score  = r_class_score;
  assign result_valid = r_result_valid;
  assign overrun      = r_overrun;

endmodule : cnn_score_reducer
`default_nettype wire

// File: tb/tb_cnn_score_reducer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_score_reducer
// Brief    : Scoreboard bench for cnn_score_reducer with a 4-pixel frame.
//            Frames are summed and argmax'd by a plain-arithmetic model; a
//            monitor compares each presented result against the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_score_reducer;

  localparam int CH    = 5;
  localparam int SW    = 16;
  localparam int NPIX  = 4;
  localparam int ACC_W = SW + $clog2(NPIX) + 1;
  localparam int ID_W  = $clog2(CH);
  localparam int VW    = CH * SW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clk_en = 1'b0;
  logic [VW-1:0]    in_data = '0;
  logic             in_valid = 1'b0;
  logic [ID_W-1:0]  class_id;
  logic [ACC_W-1:0] class_score;
  logic             result_valid;
  logic             result_ready = 1'b0;
  logic             overrun;

  cnn_score_reducer #(
    .CHANNELS_OUT (CH),
    .SCORE_W      (SW),
    .OUT_PIXELS   (NPIX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .class_id     (class_id),
    .class_score  (class_score),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     id;
    longint score;
  } exp_t;

  exp_t          exp_q[$];
  logic [VW-1:0] frame_q[$];
  int            n_vec = 0;
  int            n_bad = 0;
  bit            busy  = 1'b0;

  // monitor state
  bit               mon_prev = 1'b0;
  logic [ID_W-1:0]  mon_id;
  logic [ACC_W-1:0] mon_sc;
  exp_t             mon_e;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] pack(input int s0, input int s1, input int s2,
                                         input int s3, input int s4);
    logic [VW-1:0] v;
    v = {16'(s4), 16'(s3), 16'(s2), 16'(s1), 16'(s0)};
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    v = VW'({$urandom, $urandom, $urandom});
    return v;
  endfunction

  // Reference: a frame is the NPIX accepted pixels; winner is the first max
  task automatic model_accept(input logic [VW-1:0] v);
    longint sums[CH];
    int     best;
    frame_q.push_back(v);
    if (frame_q.size() == NPIX) begin
      foreach (sums[c]) sums[c] = 0;
      foreach (frame_q[p]) begin
        logic [VW-1:0] pv;
        pv = frame_q[p];
        for (int c = 0; c < CH; c++) begin
          logic signed [SW-1:0] s;
          s = pv[SW*c +: SW];
          sums[c] += longint'(s);
        end
      end
      best = 0;
      for (int c = 1; c < CH; c++) begin
        if (sums[c] > sums[best]) best = c;
      end
      exp_q.push_back('{id: best, score: sums[best]});
      frame_q.delete();
      busy = 1'b1;
    end
  endtask

  // One clock of stimulus; pixel counts only if enabled and the block is idle
  task automatic drive(input bit valid, input bit en, input logic [VW-1:0] data);
    in_valid = valid;
    clk_en   = en;
    in_data  = data;
    @(posedge clk);
    #1;
    if (valid && en && !busy) model_accept(data);
    in_valid = 1'b0;
    clk_en   = 1'b1;
    in_data  = rand_vec();
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!result_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!result_valid) check("result_timeout", 0, 1);
  endtask

  task automatic accept(input int hold);
    result_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    busy = 1'b0;
    check("valid_drop", result_valid, 0);
  endtask

  // Monitor: pop expected result on each new presentation, then watch it hold
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_prev = 1'b0;
      end else begin
        if (result_valid && !mon_prev) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_result: got id %0d score %0d, expected none",
                     class_id, $signed(class_score));
          end else begin
            mon_e = exp_q.pop_front();
            check("class_id", class_id, mon_e.id);
            check("class_score", $signed(class_score), mon_e.score);
          end
          mon_id = class_id;
          mon_sc = class_score;
        end else if (result_valid && mon_prev) begin
          check("hold_stable", ({class_id, class_score} === {mon_id, mon_sc}), 1);
        end
        mon_prev = result_valid;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            lat;
    logic [VW-1:0] v;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_class_id", class_id, 0);
    check("rst_class_score", class_score, 0);
    check("rst_valid", result_valid, 0);
    check("rst_overrun", overrun, 0);
    rst_n  = 1'b1;
    clk_en = 1'b1;
    @(posedge clk);
    #1;

    // constant frame, latency and long hold
    v = pack(1, 2, 3, 9, -5);
    repeat (NPIX) drive(1, 1, v);
    wait_result(lat);
    check("latency", lat, 6);
    check("const_id", class_id, 3);
    check("const_score", $signed(class_score), 36);
    check("const_overrun", overrun, 0);
    accept(10);

    // negative scores with a tie
    v = pack(-3, -1, -1, -7, -2);
    repeat (NPIX) drive(1, 1, v);
    wait_result(lat);
    check("tie_id", class_id, 1);
    check("tie_score", $signed(class_score), -4);
    accept(0);

    // full-scale negative on every channel: no wrap, lowest index wins
    v = pack(-32768, -32768, -32768, -32768, -32768);
    repeat (NPIX) drive(1, 1, v);
    wait_result(lat);
    check("fs_id", class_id, 0);
    check("fs_score", $signed(class_score), -131072);
    check("fs_overrun", overrun, 0);
    accept(2);

    // overrun: pixels during argmax are dropped
    repeat (NPIX) drive(1, 1, rand_vec());
    drive(1, 1, pack(30000, 30000, 30000, 30000, 30000));
    drive(1, 1, pack(30000, 30000, 30000, 30000, 30000));
    wait_result(lat);
    check("ovr_flag", overrun, 1);
    accept(1);
    repeat (NPIX - 1) drive(1, 1, rand_vec());
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    check("ovr_no_early", result_valid, 0);
    drive(1, 1, rand_vec());
    wait_result(lat);
    check("ovr_sticky", overrun, 1);
    accept(0);

    // clk_en gating mid-frame, and ready ignored while disabled
    repeat (2) drive(1, 1, pack(5, 6, 7, 8, 9));
    repeat (3) drive(1, 0, pack(1000, 1000, 1000, 1000, 1000));
    repeat (2) drive(1, 1, pack(5, 6, 7, 8, 9));
    wait_result(lat);
    check("gate_id", class_id, 4);
    check("gate_score", $signed(class_score), 36);
    clk_en       = 1'b0;
    result_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("gate_ready_ignored", result_valid, 1);
    result_ready = 1'b0;
    clk_en       = 1'b1;
    accept(0);

    // async reset mid-frame
    repeat (2) drive(1, 1, pack(100, 100, 100, 100, 20000));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_class_id", class_id, 0);
    check("arst_class_score", class_score, 0);
    check("arst_valid", result_valid, 0);
    check("arst_overrun", overrun, 0);
    frame_q.delete();
    #2;
    rst_n = 1'b1;
    repeat (NPIX) drive(1, 1, pack(-1, 2, -3, 4, 1));
    wait_result(lat);
    check("arst_id", class_id, 3);
    check("arst_score", $signed(class_score), 16);
    accept(0);

    // randomized frames with bubbles, enable drops and ready delays
    for (int f = 0; f < 20; f++) begin
      int guard;
      guard = 0;
      while (!busy && guard < 200) begin
        drive(($urandom % 4) != 0, ($urandom % 5) != 0, rand_vec());
        guard++;
      end
      wait_result(lat);
      accept($urandom % 4);
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_cnn_score_reducer
`default_nettype wire
